// File: rtl/serial_subtract_four_bit.sv
// serial_subtract_four_bit: bit-serial A - B - Bin, one bit per cycle, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output.
module serial_subtract_four_bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, bout_q, bout_d;
  logic accept, d, br_nx, last;
`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif
  always_comb begin
    accept = start && state_q != RUN;
    d      = a_q[0] ^ b_q[0] ^ br_q;
    br_nx  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last   = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      state_d = RUN;
      a_d     = A;
      b_d     = B;
      br_d    = Bin;
      cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_d = A[WIDTH-1];
      b_msb_d = B[WIDTH-1];
`endif
    end else if (state_q == RUN) begin
      a_d    = a_q >> 1;
      b_d    = b_q >> 1;
      diff_d = {d, diff_q[WIDTH-1:1]};
      br_d   = br_nx;
      cnt_d  = cnt_q + CW'(1);
      // Publish on the same edge that enters DONE so outputs are valid in the done cycle.
      if (last) begin
        state_d = DONE;
        res_d   = {d, diff_q[WIDTH-1:1]};
        bout_d  = br_nx;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = (a_msb_q != b_msb_q) && (d != a_msb_q);
`endif
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end
  assign busy   = state_q == RUN;
  assign done   = state_q == DONE;
  assign result = res_q;
  assign Bout   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign overflow = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtract_four_bit.sv
// tb_serial_subtract_four_bit: directed vectors and handshake corner cases for the serial subtractor.
module tb_serial_subtract_four_bit;
  localparam int W = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, bout;
  logic [W-1:0] result;
`ifdef SERIAL_SUB_OVF_EN
  logic overflow;
`endif
  int tests = 0, fails = 0;
  serial_subtract_four_bit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Bin(bin),
    .busy(busy), .done(done), .result(result), .Bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .overflow(overflow)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] a, b;
    logic bin;
    logic [W-1:0] res;
    logic bout;
  } vec_t;
  vec_t v[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic ovf_of(input vec_t t);
    return (t.a[W-1] != t.b[W-1]) && (t.res[W-1] != t.a[W-1]);
  endfunction
  task automatic check_outputs(input string tag, input vec_t t);
    chk({tag, " result"}, result, t.res);
    chk({tag, " Bout"}, bout, t.bout);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, " overflow"}, overflow, ovf_of(t));
`endif
  endtask
  // Start in cycle 0, scramble inputs afterwards, check busy 1..4, done in 5, then a single pulse.
  task automatic run_vec(input vec_t t, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    start = 1'b1; a = t.a; b = t.b; bin = t.bin;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      start = 1'b0; a = ~t.a; b = ~t.b; bin = ~t.bin;
      chk($sformatf("%s busy c%0d", tag, i), busy, 1'b1);
      chk($sformatf("%s done c%0d", tag, i), done, 1'b0);
    end
    @(negedge clk);
    chk({tag, " done pulse"}, done, 1'b1);
    chk({tag, " busy in done"}, busy, 1'b0);
    check_outputs(tag, t);
    @(negedge clk);
    chk({tag, " done drop"}, done, 1'b0);
    check_outputs({tag, " hold"}, t);
  endtask
  initial begin
    vec_t t1, t2;
    int dones;
    v[0] = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0};
    v[1] = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1};
    v[2] = '{4'h5, 4'h5, 1'b1, 4'hF, 1'b1};
    v[3] = '{4'h7, 4'h2, 1'b0, 4'h5, 1'b0};
    v[4] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0};
    v[5] = '{4'h2, 4'h1, 1'b0, 4'h1, 1'b0};
    v[6] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    v[7] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    v[8] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b1};
    v[9] = '{4'hF, 4'h0, 1'b1, 4'hE, 1'b0};
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset result", result, 4'h0);
    chk("reset Bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    chk("reset overflow", overflow, 1'b0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) run_vec(v[i], i);
    // Back-to-back: second start held in the done cycle.
    t1 = v[2]; t2 = v[3];
    @(negedge clk);
    start = 1'b1; a = t1.a; b = t1.b; bin = t1.bin;
    @(negedge clk);
    start = 1'b0;
    repeat (W) @(negedge clk);
    chk("b2b first done", done, 1'b1);
    check_outputs("b2b first", t1);
    start = 1'b1; a = t2.a; b = t2.b; bin = t2.bin;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("b2b busy c%0d", i), busy, 1'b1);
      chk($sformatf("b2b hold result c%0d", i), result, t1.res);
    end
    @(negedge clk);
    chk("b2b second done", done, 1'b1);
    check_outputs("b2b second", t2);
    // Start while busy is ignored.
    t1 = v[0];
    @(negedge clk);
    start = 1'b1; a = t1.a; b = t1.b; bin = t1.bin;
    dones = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = (i == 2); a = 4'h1; b = 4'h8; bin = 1'b1;
      if (done) begin
        dones++;
        chk("ignored start cycle", i, W + 1);
        check_outputs("ignored start", t1);
      end
    end
    chk("ignored start done count", dones, 1);
    // Asynchronous reset mid-run.
    @(negedge clk);
    start = 1'b1; a = 4'h3; b = 4'h9; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async rst busy", busy, 1'b0);
    chk("async rst done", done, 1'b0);
    chk("async rst result", result, 4'h0);
    chk("async rst Bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    chk("async rst overflow", overflow, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("post reset quiet", dones, 0);
    run_vec(v[4], 40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
